// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter:
// FSM state encoding, seven-segment patterns and the double-dabble nibble fix-up.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [3:0] add3_nibble(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_seq_converter_seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Non-decimal codes blank the display.
module seg7_decoder
    import bcd_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Digit lookup; anything outside 0-9 is blanked
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative shift-add-3 binary-to-BCD converter with start/busy/done handshake,
// one shift per clock, driving four active-low seven-segment displays.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int N      = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [N-1:0]          bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [6:0]            display_unidad,
    output logic [6:0]            display_decena,
    output logic [6:0]            display_centena,
    output logic [6:0]            display_miles
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + N;
    localparam int CW = $clog2(N + 1);

    if (10 ** DIGITS <= 2 ** N - 1) begin : g_range_err
        $error("bcd_seq_converter: 2**N-1 does not fit in DIGITS decimal digits");
    end
    if (DIGITS < 4) begin : g_digit_err
        $error("bcd_seq_converter: at least four digits are needed for the displays");
    end

    state_e          r_state;
    logic [SW-1:0]   r_shift;
    logic [CW-1:0]   r_count;
    logic            r_busy;
    logic            r_done;
    logic [BW-1:0]   r_bcd;

    logic [SW-1:0]   w_corr;
    logic [SW-1:0]   w_next_shift;
    logic [6:0]      w_seg [DIGITS];

    // Add-3 fix-up on every BCD nibble of the current register, then shift left
    always_comb begin
        w_corr = r_shift;
        for (int d = 0; d < DIGITS; d++) begin
            w_corr[N + 4*d +: 4] = add3_nibble(r_shift[N + 4*d +: 4]);
        end
        w_next_shift = {w_corr[SW-2:0], 1'b0};
    end

    // Conversion sequencer and result/handshake registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_shift <= {SW{1'b0}};
            r_count <= {CW{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bcd   <= {BW{1'b0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift <= {{BW{1'b0}}, bin_in};
                        r_count <= CW'(N);
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_shift <= w_next_shift;
                    r_count <= r_count - CW'(1);
                    // Last of the N iterations happens on this edge
                    if (r_count == CW'(1)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    r_bcd   <= r_shift[SW-1 -: BW];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bcd_out = r_bcd;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_decoder u_dec (
            .i_bcd (r_bcd[4*g +: 4]),
            .o_seg (w_seg[g])
        );
    end

    assign display_unidad  = w_seg[0];
    assign display_decena  = w_seg[1];
    assign display_centena = w_seg[2];
    assign display_miles   = w_seg[3];

endmodule
